data_frame_accum: RTL and testbench
===================================

Name: data_frame_accum

Overview:
Downstream consumer of the multi-function data processor's registered signed 9-bit result. It collects N consecutive valid results into a frame. For each frame it produces a saturating signed sum, a running maximum and a running minimum, then presents them on a valid/ready output with full backpressure. It sits between the data processor and any statistics or reporting logic.

Parameters:
DW, 9, signed input sample width (matches data processor result width)
N, 4, samples per frame; legal range 2..255
SW, 12, signed sum output width; must be >= DW

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous abort: discard partial frame and any pending output
in_valid  input  1  in_data is valid this cycle
in_data  input  DW  signed sample
in_ready  output  1  block can accept a sample this cycle
out_valid  output  1  frame result available
out_ready  input  1  downstream accepts result
out_sum  output  SW  signed saturated sum of the N samples
out_max  output  DW  signed maximum of the frame
out_min  output  DW  signed minimum of the frame
out_sat  output  1  saturation occurred at any point in the frame
out_cnt  output  8  samples accepted in the current frame (debug)

Behaviour:
- Reset (rst=1 at a rising edge), all outputs:
  - out_valid=0, out_sum=0, out_max=0, out_min=0, out_sat=0, out_cnt=0.
  - State ACCUM, so in_ready=1 in the first cycle after reset.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready is derived from state only; it never depends combinationally on in_valid or out_ready.
- Accept: in_valid && in_ready at a rising edge.
- First sample of a frame (out_cnt=0):
  - acc <= sign-extend(in_data); max <= in_data; min <= in_data; sat <= 0.
- Later samples:
  - acc <= sat_add(acc, sext(in_data)); max/min updated with signed compare.
  - sat latches 1 if any add clips.
- Saturation: the sum is computed at SW+1 bits. Results above 2^(SW-1)-1 clamp to the maximum; results below -2^(SW-1) clamp to the minimum. Later adds continue from the clamped value.
- Nth accepted sample:
  - Registers include that sample; state goes to HOLD; out_valid=1 on the next cycle (latency 1 clock from last accept).
  - out_cnt returns to 0 on the same edge.
- HOLD:
  - out_sum, out_max, out_min and out_sat stay stable until the handshake.
  - Handshake is out_valid && out_ready at an edge.
  - On handshake, go to ACCUM: out_valid=0 and in_ready=1 next cycle. No sample is accepted in the handshake cycle.
  - Result registers keep their last values after the handshake until the next frame's first sample.
- out_ready while out_valid=0: ignored.
- clr:
  - Goes to ACCUM and sets out_cnt=0, out_valid=0, out_sat=0.
  - Priority over a simultaneous accept (that sample is dropped) and over a simultaneous output handshake (the result is lost).
  - out_sum, out_max and out_min are left unchanged.
- rst has priority over clr. Reset mid-frame or during HOLD discards everything; the next accepted sample starts a new frame.
- in_valid gaps are allowed anywhere; only accepted samples count.
- in_data with in_valid=0 is don't-care.

Test Plan:
- N=4, SW=12: accept 10, -3, 255, -256 back-to-back, out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=6, out_max=255, out_min=-256, out_sat=0; out_valid=0 on the next cycle.
- Backpressure: same frame, out_ready=0 for 5 cycles with in_valid=1 held -> in_ready=0 throughout, outputs constant. Then out_ready=1 -> handshake, in_ready=1 on the following cycle, and the first sample accepted afterwards starts a new frame (out_cnt=1).
- Saturation, SW=10: accept 255 four times -> out_sum=511, out_sat=1, out_max=out_min=255. Accept -256 four times -> out_sum=-512, out_sat=1.
- Gapped input: 1, idle, idle, 2, idle, 3, 4 -> out_sum=10, out_max=4, out_min=1; out_cnt steps 1, 2, 3 then 0.
- clr asserted in the same cycle as the 3rd accepted sample -> out_cnt=0, no out_valid. The next 4 samples 5, 5, 5, 5 -> out_sum=20.
- rst for 1 cycle during HOLD (out_valid=1) -> next cycle out_valid=0, in_ready=1, out_sum=0, out_max=0, out_min=0, out_sat=0, out_cnt=0.

Source files
------------

// File: rtl/data_frame_accum.sv
`default_nettype none
// ============================================================================
// Module   : data_frame_accum
// Brief    : Collects N accepted signed samples into a frame and presents a
//            saturating sum, maximum, minimum and saturation flag on a
//            valid/ready output with full backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module data_frame_accum #(
  parameter int DW = 9,   // signed sample width
  parameter int N  = 4,   // samples per frame (2..255)
  parameter int SW = 12   // signed sum width (>= DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [DW-1:0] out_max,
  output logic [DW-1:0] out_min,
  output logic          out_sat,
  output logic [7:0]    out_cnt
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0]           LAST_CNT = 8'(N - 1);
  localparam logic signed [SW-1:0] SUM_MAX  = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN  = {1'b1, {(SW-1){1'b0}}};

  state_t               state_q, state_d;
  logic signed [SW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] max_q, max_d;
  logic signed [DW-1:0] min_q, min_d;
  logic                 sat_q, sat_d;
  logic [7:0]           cnt_q, cnt_d;

  logic signed [DW-1:0] sample;
  logic signed [SW:0]   sum_wide;
  logic signed [SW-1:0] sum_clamped;
  logic                 add_clip;
  logic                 accept;
  logic                 last_sample;

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign accept      = in_valid && in_ready;
  assign last_sample = (cnt_q == LAST_CNT);
  assign sample      = $signed(in_data);

  // Sum one bit wider than the accumulator so overflow shows as a sign split.
  assign sum_wide = (SW+1)'(acc_q) + (SW+1)'(sample);

  // Clamp the wide sum back into SW bits, flagging any clip.
  always_comb begin
    add_clip    = (sum_wide[SW] != sum_wide[SW-1]);
    sum_clamped = sum_wide[SW-1:0];
    if (add_clip) begin
      sum_clamped = sum_wide[SW] ? SUM_MIN : SUM_MAX;
    end
  end

  // Frame state: fill in ACCUM, present result in HOLD until handshake.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last_sample) state_d = HOLD;
        HOLD:    if (out_ready)             state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Datapath next state: first sample seeds the frame, later ones fold in.
  always_comb begin
    acc_d = acc_q;
    max_d = max_q;
    min_d = min_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
    if (clr) begin
      // Partial frame and pending result are dropped; stats are kept.
      cnt_d = 8'd0;
      sat_d = 1'b0;
    end else if (accept) begin
      cnt_d = last_sample ? 8'd0 : cnt_q + 8'd1;
      if (cnt_q == 8'd0) begin
        acc_d = SW'(sample);
        max_d = sample;
        min_d = sample;
        sat_d = 1'b0;
      end else begin
        acc_d = sum_clamped;
        if (sample > max_q) max_d = sample;
        if (sample < min_q) min_d = sample;
        sat_d = sat_q | add_clip;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      min_q   <= min_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sum = acc_q;
  assign out_max = max_q;
  assign out_min = min_q;
  assign out_sat = sat_q;
  assign out_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_frame_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_frame_accum
// Brief    : Scoreboard bench for data_frame_accum. Instance A uses SW=12,
//            instance B uses SW=10 to reach saturation within one frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_frame_accum;

  typedef struct {
    int sum;
    int mx;
    int mn;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A signals
  logic        a_clr = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [8:0]  a_in_data = '0;
  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [11:0] a_out_sum;
  logic [8:0]  a_out_max, a_out_min;
  logic [7:0]  a_out_cnt;

  // Instance B signals
  logic        b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [8:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [9:0]  b_out_sum;
  logic [8:0]  b_out_max, b_out_min;
  logic [7:0]  b_out_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t qa[$];
  exp_t qb[$];

  data_frame_accum #(.DW(9), .N(4), .SW(12)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_max(a_out_max), .out_min(a_out_min),
    .out_sat(a_out_sat), .out_cnt(a_out_cnt)
  );

  data_frame_accum #(.DW(9), .N(4), .SW(10)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_max(b_out_max), .out_min(b_out_min),
    .out_sat(b_out_sat), .out_cnt(b_out_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(int s, int mx, int mn, int sat);
    exp_t e;
    e.sum = s; e.mx = mx; e.mn = mn; e.sat = sat;
    return e;
  endfunction

  // Monitor A: compare each handed-off frame against the scoreboard.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        chk("A_unexpected_frame", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("A_sum", int'($signed(a_out_sum)), e.sum);
        chk("A_max", int'($signed(a_out_max)), e.mx);
        chk("A_min", int'($signed(a_out_min)), e.mn);
        chk("A_sat", int'(a_out_sat), e.sat);
      end
    end
  end

  // Monitor B: same for the narrow-sum instance.
  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        chk("B_unexpected_frame", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("B_sum", int'($signed(b_out_sum)), e.sum);
        chk("B_max", int'($signed(b_out_max)), e.mx);
        chk("B_min", int'($signed(b_out_min)), e.mn);
        chk("B_sat", int'(b_out_sat), e.sat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_put(input int v);
    a_in_valid = 1'b1;
    a_in_data  = 9'(v);
    step();
  endtask

  task automatic b_put(input int v);
    b_in_valid = 1'b1;
    b_in_data  = 9'(v);
    step();
  endtask

  task automatic a_idle();
    a_in_valid = 1'b0;
    step();
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_in_ready",  int'(a_in_ready), 1);
    chk("rst_out_sum",   int'($signed(a_out_sum)), 0);
    chk("rst_out_cnt",   int'(a_out_cnt), 0);
    chk("rst_out_sat",   int'(a_out_sat), 0);
    rst = 1'b0;
    step();

    // Basic frame, out_ready high
    a_out_ready = 1'b1;
    a_put(10);
    chk("basic_cnt1", int'(a_out_cnt), 1);
    a_put(-3);
    a_put(255);
    qa.push_back(mk(6, 255, -256, 0));
    a_put(-256);
    a_in_valid = 1'b0;
    chk("basic_valid_lat1", int'(a_out_valid), 1);
    chk("basic_in_ready_hold", int'(a_in_ready), 0);
    chk("basic_cnt_wrap", int'(a_out_cnt), 0);
    step();
    chk("basic_valid_drop", int'(a_out_valid), 0);
    chk("basic_in_ready_back", int'(a_in_ready), 1);

    // Backpressure with in_valid held high
    a_out_ready = 1'b0;
    a_put(10);
    a_put(-3);
    a_put(255);
    qa.push_back(mk(6, 255, -256, 0));
    a_put(-256);
    a_in_valid = 1'b1;
    a_in_data  = 9'(77);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(a_in_ready), 0);
      chk("bp_out_valid", int'(a_out_valid), 1);
      chk("bp_out_sum", int'($signed(a_out_sum)), 6);
      step();
    end
    a_out_ready = 1'b1;
    step();
    chk("bp_in_ready_after_hs", int'(a_in_ready), 1);
    chk("bp_cnt_after_hs", int'(a_out_cnt), 0);
    step();
    chk("bp_new_frame_cnt", int'(a_out_cnt), 1);
    chk("bp_new_frame_sum", int'($signed(a_out_sum)), 77);
    a_put(1);
    a_put(1);
    qa.push_back(mk(80, 77, 1, 0));
    a_put(1);
    a_in_valid = 1'b0;
    step();

    // Gapped input
    a_put(1);
    chk("gap_cnt1", int'(a_out_cnt), 1);
    a_idle();
    a_idle();
    a_put(2);
    chk("gap_cnt2", int'(a_out_cnt), 2);
    a_idle();
    a_put(3);
    chk("gap_cnt3", int'(a_out_cnt), 3);
    qa.push_back(mk(10, 4, 1, 0));
    a_put(4);
    a_in_valid = 1'b0;
    chk("gap_cnt0", int'(a_out_cnt), 0);
    chk("gap_valid", int'(a_out_valid), 1);
    step();

    // clr together with the 3rd accepted sample
    a_put(9);
    a_put(9);
    a_clr = 1'b1;
    a_put(9);
    a_clr = 1'b0;
    a_in_valid = 1'b0;
    chk("clr_cnt", int'(a_out_cnt), 0);
    chk("clr_valid", int'(a_out_valid), 0);
    step();
    chk("clr_valid_later", int'(a_out_valid), 0);
    a_put(5);
    a_put(5);
    a_put(5);
    qa.push_back(mk(20, 5, 5, 0));
    a_put(5);
    a_in_valid = 1'b0;
    step();

    // Reset during HOLD
    a_out_ready = 1'b0;
    a_put(3);
    a_put(3);
    a_put(3);
    a_put(3);
    a_in_valid = 1'b0;
    chk("hold_before_rst", int'(a_out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstH_out_valid", int'(a_out_valid), 0);
    chk("rstH_in_ready",  int'(a_in_ready), 1);
    chk("rstH_out_sum",   int'($signed(a_out_sum)), 0);
    chk("rstH_out_max",   int'($signed(a_out_max)), 0);
    chk("rstH_out_min",   int'($signed(a_out_min)), 0);
    chk("rstH_out_sat",   int'(a_out_sat), 0);
    chk("rstH_out_cnt",   int'(a_out_cnt), 0);
    a_out_ready = 1'b1;
    step();

    // Saturation on the SW=10 instance
    b_put(255);
    b_put(255);
    b_put(255);
    qb.push_back(mk(511, 255, 255, 1));
    b_put(255);
    b_in_valid = 1'b0;
    step();
    b_put(-256);
    b_put(-256);
    b_put(-256);
    qb.push_back(mk(-512, -256, -256, 1));
    b_put(-256);
    b_in_valid = 1'b0;
    step();
    // Saturation flag clears on the following frame
    b_put(1);
    b_put(-1);
    b_put(2);
    qb.push_back(mk(3, 2, -1, 0));
    b_put(1);
    b_in_valid = 1'b0;
    step();
    step();

    chk("A_scoreboard_drained", qa.size(), 0);
    chk("B_scoreboard_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
